// File: rtl/m68k_bram_responder_if.sv
// Bus bundle between the 68k initiator, the responder and its byte-wide BRAM.
// berr_n is only present when M68_RESP_BERR_EN is defined.
interface m68k_bram_responder_if;
  // Handshake: the initiator drives as_n low with addr/rw/lanes/wdata stable.
  // The responder answers by pulling dtack_n (or berr_n) low and holds it until
  // it samples as_n high. The initiator must then drive as_n high for at least
  // one sampled edge before it starts the next cycle.
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        dtack_n;
`ifdef M68_RESP_BERR_EN
  logic        berr_n;
`endif
  logic        ena;
  logic        wea;
  logic [16:0] addra;
  logic [7:0]  dina;
  logic [7:0]  douta;

`ifdef M68_RESP_BERR_EN
  modport slave (
    input  as_n, uds_n, lds_n, rw, addr, wdata, douta,
    output rdata, dtack_n, berr_n, ena, wea, addra, dina
  );
  modport master (
    output as_n, uds_n, lds_n, rw, addr, wdata, douta,
    input  rdata, dtack_n, berr_n, ena, wea, addra, dina
  );
`else
  modport slave (
    input  as_n, uds_n, lds_n, rw, addr, wdata, douta,
    output rdata, dtack_n, ena, wea, addra, dina
  );
  modport master (
    output as_n, uds_n, lds_n, rw, addr, wdata, douta,
    input  rdata, dtack_n, ena, wea, addra, dina
  );
`endif
endinterface

// File: rtl/m68k_bram_responder.sv
// 68000-style bus responder that splits each 16-bit access into two byte cycles
// on a single-port BRAM. Optional feature macro: M68_RESP_BERR_EN (bus error on miss).
module m68k_bram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFE_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  m68k_bram_responder_if.slave  bus,
  output logic [2:0]            fsm_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LANE_HI = 3'd1;
  localparam logic [2:0] LANE_LO = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] ACK     = 3'd4;

  // Edge numbers (counted from the accepting edge E0) at which each read byte lands.
  localparam logic [2:0] HI_CAP = 3'(RD_LAT + 1);
  localparam logic [2:0] LO_CAP = 3'(RD_LAT + 2);

  logic [2:0]  state;
  logic [2:0]  edge_cnt;
  logic [15:0] word_q;
  logic        rw_q;
  logic        hit_q;
  logic        hi_en_q;
  logic        lo_en_q;
  logic [7:0]  wlo_q;
  logic [7:0]  rd_hi_q;
  logic        req_hit;
  logic        addr_unused;

  assign req_hit     = (bus.addr & ADDR_MASK) == BASE_ADDR;
  assign addr_unused = bus.addr[0];
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      edge_cnt    <= 3'd0;
      word_q      <= 16'h0000;
      rw_q        <= 1'b1;
      hit_q       <= 1'b0;
      hi_en_q     <= 1'b0;
      lo_en_q     <= 1'b0;
      wlo_q       <= 8'h00;
      rd_hi_q     <= 8'hFF;
      bus.rdata   <= 16'h0000;
      bus.dtack_n <= 1'b1;
`ifdef M68_RESP_BERR_EN
      bus.berr_n  <= 1'b1;
`endif
      bus.ena     <= 1'b0;
      bus.wea     <= 1'b0;
      bus.addra   <= 17'd0;
      bus.dina    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.as_n) begin
            state    <= LANE_HI;
            edge_cnt <= 3'd1;
            word_q   <= bus.addr[16:1];
            rw_q     <= bus.rw;
            hit_q    <= req_hit;
            hi_en_q  <= req_hit & ~bus.uds_n;
            lo_en_q  <= req_hit & ~bus.lds_n;
            wlo_q    <= bus.wdata[7:0];
            bus.ena  <= req_hit & ~bus.uds_n;
            bus.wea  <= req_hit & ~bus.uds_n & ~bus.rw;
            bus.addra <= {bus.addr[16:1], 1'b0};
            bus.dina <= bus.wdata[15:8];
          end
        end
        LANE_HI: begin
          if (bus.as_n) begin
            state   <= IDLE;
            bus.ena <= 1'b0;
            bus.wea <= 1'b0;
          end else begin
            state     <= LANE_LO;
            edge_cnt  <= edge_cnt + 3'd1;
            bus.ena   <= lo_en_q;
            bus.wea   <= lo_en_q & ~rw_q;
            bus.addra <= {word_q, 1'b1};
            bus.dina  <= wlo_q;
          end
        end
        LANE_LO: begin
          bus.ena <= 1'b0;
          bus.wea <= 1'b0;
          if (bus.as_n) begin
            state <= IDLE;
          end else begin
            edge_cnt <= edge_cnt + 3'd1;
            if (edge_cnt == HI_CAP) rd_hi_q <= hi_en_q ? bus.douta : 8'hFF;
            if (!hit_q) begin
              state <= ACK;
`ifdef M68_RESP_BERR_EN
              bus.berr_n <= 1'b0;
`else
              bus.dtack_n <= 1'b0;
              if (rw_q) bus.rdata <= 16'hFFFF;
`endif
            end else if (!rw_q) begin
              state       <= ACK;
              bus.dtack_n <= 1'b0;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (bus.as_n) begin
            state <= IDLE;
          end else begin
            edge_cnt <= edge_cnt + 3'd1;
            if (edge_cnt == HI_CAP) rd_hi_q <= hi_en_q ? bus.douta : 8'hFF;
            if (edge_cnt == LO_CAP) begin
              state       <= ACK;
              bus.dtack_n <= 1'b0;
              bus.rdata   <= {rd_hi_q, lo_en_q ? bus.douta : 8'hFF};
            end
          end
        end
        ACK: begin
          // Hold the acknowledge until the initiator drops its strobe.
          if (bus.as_n) begin
            state       <= IDLE;
            bus.dtack_n <= 1'b1;
`ifdef M68_RESP_BERR_EN
            bus.berr_n  <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
